ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable). The block runs the full bus sequence: inhibit, request-to-send, 11 device-clocked bits, then acknowledge sampling. It sits beside the keyboard receive path on the same PS2_CLK/PS2_DATA pins. The top level turns the open-drain enables into pin drives, and uses `busy` to mask the receive path while a transmission is on the bus.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_line_sync.sv | 41 ++++
 rtl/ps2_host_tx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
// Shared PS/2 definitions: host-transmit state encoding, frame builder,
// keyboard command bytes and device response codes.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_DONE
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;

  localparam int TX_MAX_RETRIES = 2;

  // Bits after the start bit, LSB first: data[7:0], odd parity, stop.
  function automatic logic [9:0] ps2_tx_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
`timescale 1ns/1ps
// Two-flop synchronizers for the PS/2 clock and data pins plus a one-cycle
// pulse on each synchronized PS2_CLK falling edge. Shared with the receive path.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall
);

  logic [1:0] clk_sync_q, clk_sync_d;
  logic [1:0] data_sync_q, data_sync_d;
  logic       clk_prev_q, clk_prev_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], clk_in};
    data_sync_d = {data_sync_q[0], data_in};
    clk_prev_d  = clk_sync_q[1];
  end

  // Reset to the idle-bus level so no spurious edge appears after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  assign clk_s    = clk_sync_q[1];
  assign data_s   = data_sync_q[1];
  assign clk_fall = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11
// device-clocked bits, acknowledge. Define PS2_TX_RETRY_EN for automatic retries.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int RTS_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  import ps2_pkg::*;

  localparam int CNT_MAX_A = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [9:0]       frame_q, frame_d;
  logic             data_bit_q, data_bit_d;

  logic clk_s, data_s, clk_fall;
  logic on_bus, timeout, retry_left;
  ps2_tx_state_e fail_state;

  ps2_line_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_in   (ps2_clk_in),
    .data_in  (ps2_data_in),
    .clk_s    (clk_s),
    .data_s   (data_s),
    .clk_fall (clk_fall)
  );

`ifdef PS2_TX_RETRY_EN
  logic [1:0] retry_q, retry_d;

  assign retry_left = (retry_q != 2'(TX_MAX_RETRIES));

  always_comb begin
    retry_d = retry_q;
    if (state_q == ST_IDLE)
      retry_d = 2'd0;
    else if (state_d == ST_INHIBIT)
      retry_d = retry_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retry_q <= 2'd0;
    else        retry_q <= retry_d;
  end
`else
  assign retry_left = 1'b0;
`endif

  // The timeout window spans everything after PS2_CLK is handed to the device.
  assign on_bus     = (state_q == ST_SEND) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
  assign timeout    = on_bus && (cnt_q == TO_LAST);
  assign fail_state = retry_left ? ST_INHIBIT : ST_DONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (tx_valid) state_d = ST_INHIBIT;
      ST_INHIBIT:   if (cnt_q == INH_LAST) state_d = ST_RTS;
      ST_RTS:       if (cnt_q == RTS_LAST) state_d = ST_SEND;
      ST_SEND: begin
        if (timeout)                              state_d = fail_state;
        else if (clk_fall && bit_cnt_q == 4'd9)   state_d = ST_ACK;
      end
      ST_ACK: begin
        if (timeout)       state_d = fail_state;
        else if (clk_fall) state_d = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (timeout)              state_d = fail_state;
        else if (clk_s && data_s) state_d = ack_q ? ST_DONE : fail_state;
      end
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = '0;
    bit_cnt_d  = bit_cnt_q;
    ack_d      = ack_q;
    err_d      = err_q;
    frame_d    = frame_q;
    data_bit_d = data_bit_q;

    // INHIBIT, RTS and SEND each start a fresh count; ACK and WAIT_IDLE keep
    // accumulating so the timeout covers the whole device-clocked phase.
    if (state_d != state_q &&
        (state_d == ST_INHIBIT || state_d == ST_RTS || state_d == ST_SEND))
      cnt_d = '0;
    else if (state_q != ST_IDLE && state_q != ST_DONE)
      cnt_d = cnt_q + 1'b1;

    if (state_q == ST_IDLE) begin
      frame_d = ps2_tx_frame(tx_data);
      ack_d   = 1'b0;
    end

    if (state_d == ST_SEND && state_q != ST_SEND) begin
      bit_cnt_d  = 4'd0;
      data_bit_d = 1'b1;
    end else if (state_q == ST_SEND && clk_fall) begin
      bit_cnt_d  = bit_cnt_q + 4'd1;
      data_bit_d = ~frame_q[bit_cnt_q];
    end

    if (state_q == ST_ACK && clk_fall)
      ack_d = ~data_s;

    if (state_d == ST_DONE && state_q != ST_DONE)
      err_d = !(state_q == ST_WAIT_IDLE && !timeout && ack_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bit_cnt_q <= 4'd0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    frame_q    <= frame_d;
    data_bit_q <= data_bit_d;
  end

  // Line drives decode from state so a reset releases both pins at once.
  always_comb begin
    tx_ready    = 1'b0;
    busy        = 1'b1;
    tx_done     = 1'b0;
    tx_err      = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_INHIBIT: ps2_clk_oe = 1'b1;
      ST_RTS: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
      end
      ST_SEND:    ps2_data_oe = data_bit_q;
      ST_DONE: begin
        tx_done = 1'b1;
        tx_err  = err_q;
      end
      default: ;
    endcase
  end

endmodule
